bcd_time_counter: RTL and testbench
===================================

// Module: bcd_time_counter
// PURPOSE
//  Free-running 24-hour BCD timekeeper; producer of the curHour bus consumed by the AM/PM indicator.
//  Divides clk down to 1 Hz and counts hh:mm:ss in packed BCD: {tens[7:4], units[3:0]}.
//  Supports manual per-field stepping (set mode) and a validated parallel load.
//  Feeds the display mux and alarm compare blocks.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per second; must be >= 2
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  set_en       in   1  level; 1 = set mode, timekeeping paused
//  set_sel      in   2  field to step in set mode: 0 = sec, 1 = min, 2 = hour, 3 = none
//  set_inc      in   1  single-cycle pulse; steps the selected field by +1
//  load_valid   in   1  single-cycle pulse; load load_hour/min/sec
//  load_hour    in   8  BCD hour, 00..23
//  load_min     in   8  BCD minute, 00..59
//  load_sec     in   8  BCD second, 00..59
//  curHour      out  8  BCD hour, 00..23
//  curMin       out  8  BCD minute, 00..59
//  curSec       out  8  BCD second, 00..59
//  sec_pulse    out  1  1-cycle pulse on each counted second
//  load_err     out  1  1-cycle pulse; load rejected
// BEHAVIOUR
//  - Reset (async, rst_n = 0):
//    - curHour/curMin/curSec = 8'h00; sec_pulse = 0; load_err = 0; prescaler = 0.
//    - Counting restarts on the first clk edge after rst_n rises.
//  - Prescaler (set_en = 0): counts 0..TICK_DIV-1.
//    - On terminal count: wraps to 0, asserts sec_pulse for 1 cycle, increments time.
//    - Time outputs are registered and change on the same edge sec_pulse goes high.
//  - Increment, BCD with carry:
//    - Units 9 -> 0 carries to tens.
//    - sec 59 -> 00 carries to min; min 59 -> 00 carries to hour.
//    - Hour 23 -> 00. 23:59:59 -> 00:00:00 in one tick.
//  - Set mode (set_en = 1):
//    - Prescaler held at 0; sec_pulse held at 0.
//    - set_inc steps only the field chosen by set_sel: sec/min wrap 59 -> 00, hour 23 -> 00.
//    - Stepping never carries into another field. set_sel = 3: set_inc ignored.
//    - Leaving set mode: the first tick comes exactly TICK_DIV cycles after set_en falls.
//  - Load:
//    - Valid when each units nibble <= 9, min/sec tens <= 5, hour <= 8'h23.
//    - Valid: all three fields update on the next edge; prescaler cleared to 0.
//    - Invalid: time unchanged, load_err = 1 for 1 cycle.
//    - Load is accepted in either mode.
//  - Same-cycle priority: load_valid > set_inc > prescaler tick.
//    - A lost tick is dropped, not deferred.
//  - No output ever holds a non-BCD or out-of-range value.
// STRUCTURE
//  - Package clock_pkg:
//    - SEC_MAX = 8'h59, MIN_MAX = 8'h59, HOUR_MAX = 8'h23.
//    - Field select encodings SEL_SEC / SEL_MIN / SEL_HOUR / SEL_NONE.
//    - Function bcd_valid(value, max).
//  - Sub-module bcd_mod_counter #(MAX):
//    - Ports: clk, rst_n, inc, load, load_val, value[7:0], wrap (comb, = inc && value == MAX).
//    - Instantiated 3x.
//    - Top level holds the prescaler, set/load muxing, validation and carry chaining.
// TESTING (TICK_DIV = 4)
//  1. Release reset, run 16 cycles -> 4 sec_pulse, each 4 cycles apart; curSec = 8'h04.
//  2. Load 23:59:58 -> after 2 ticks, output 00:00:00; curHour 8'h23 -> 8'h00 on the same edge as min/sec.
//  3. Load hour = 8'h24, or min = 8'h5A -> load_err = 1 for 1 cycle; time unchanged.
//  4. set_en = 1, set_sel = 1, 3 x set_inc from min = 8'h58 -> min = 8'h01, hour unchanged, no sec_pulse.
//  5. Same cycle: load_valid and prescaler terminal count -> loaded value appears; no increment; sec_pulse = 0.
//  6. rst_n low mid-count (prescaler = 2, time 12:34:56) -> outputs 0 immediately; first tick 4 cycles after release.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared limits, field-select encodings and BCD range check for the hh:mm:ss timekeeper.
package clock_pkg;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HOUR = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  // Packed-BCD compare is order-preserving once both digits are decimal.
  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter, 00..MAX, with parallel load and combinational wrap flag.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      if (value_q == MAX) begin
        value_d = 8'h00;
      end else if (value_q[3:0] == 4'd9) begin
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= 8'h00;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign wrap  = inc && (value_q == MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour BCD timekeeper: 1 Hz prescaler, sec/min/hour chain, set-mode stepping, checked load.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  input  logic       load_valid,
  input  logic [7:0] load_hour,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] curHour,
  output logic [7:0] curMin,
  output logic [7:0] curSec,
  output logic       sec_pulse,
  output logic       load_err
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntTerm = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            load_ok, tick, step;
  logic            step_sec, step_min, step_hour;
  logic            sec_inc, min_inc, hour_inc;
  logic            sec_wrap, min_wrap, hour_wrap_unused;
  logic            sec_pulse_q, load_err_q;

  assign load_ok = load_valid && bcd_valid(load_hour, HOUR_MAX)
                   && bcd_valid(load_min, MIN_MAX) && bcd_valid(load_sec, SEC_MAX);

  // Any load request, accepted or not, pre-empts stepping and the tick in that cycle.
  assign step = set_en && set_inc && !load_valid;
  assign tick = !set_en && !load_valid && (cnt_q == CntTerm);

  always_comb begin
    step_sec  = 1'b0;
    step_min  = 1'b0;
    step_hour = 1'b0;
    if (step) begin
      unique case (set_sel)
        SEL_SEC:  step_sec  = 1'b1;
        SEL_MIN:  step_min  = 1'b1;
        SEL_HOUR: step_hour = 1'b1;
        SEL_NONE: ;
      endcase
    end
  end

  // Ticks and steps are mutually exclusive, so a stepped field never carries onward.
  assign sec_inc  = tick || step_sec;
  assign min_inc  = (tick && sec_wrap) || step_min;
  assign hour_inc = (tick && sec_wrap && min_wrap) || step_hour;

  always_comb begin
    if (set_en || load_ok || (cnt_q == CntTerm)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sec_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sec_pulse_q <= tick;
      load_err_q  <= load_valid && !load_ok;
    end
  end

  bcd_mod_counter #(
    .MAX(SEC_MAX)
  ) u_sec (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (sec_inc),
    .load    (load_ok),
    .load_val(load_sec),
    .value   (curSec),
    .wrap    (sec_wrap)
  );

  bcd_mod_counter #(
    .MAX(MIN_MAX)
  ) u_min (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (min_inc),
    .load    (load_ok),
    .load_val(load_min),
    .value   (curMin),
    .wrap    (min_wrap)
  );

  bcd_mod_counter #(
    .MAX(HOUR_MAX)
  ) u_hour (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (hour_inc),
    .load    (load_ok),
    .load_val(load_hour),
    .value   (curHour),
    .wrap    (hour_wrap_unused)
  );

  assign sec_pulse = sec_pulse_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench: a seconds-of-day reference model queues expected outputs per clock edge.
module tb_bcd_time_counter;

  localparam int Div = 4;
  localparam int Day = 86400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_en = 1'b0;
  logic [1:0] set_sel = 2'd3;
  logic       set_inc = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_hour = 8'h00;
  logic [7:0] load_min = 8'h00;
  logic [7:0] load_sec = 8'h00;
  logic [7:0] curHour, curMin, curSec;
  logic       sec_pulse, load_err;

  typedef struct {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       p;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state: time as seconds since midnight, cycles elapsed in the current second.
  int t_ref   = 0;
  int pre_ref = 0;
  bit pls_ref = 0;
  bit err_ref = 0;

  bcd_time_counter #(
    .TICK_DIV(Div)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (set_en),
    .set_sel   (set_sel),
    .set_inc   (set_inc),
    .load_valid(load_valid),
    .load_hour (load_hour),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .curHour   (curHour),
    .curMin    (curMin),
    .curSec    (curSec),
    .sec_pulse (sec_pulse),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tn, un;
    tn = 4'(v / 10);
    un = 4'(v % 10);
    return {tn, un};
  endfunction

  function automatic bit dec(input logic [7:0] b, input int lim, output int v);
    int tn, un;
    tn = int'(b[7:4]);
    un = int'(b[3:0]);
    v  = tn * 10 + un;
    return (tn <= 9) && (un <= 9) && (v < lim);
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.h = to_bcd(t_ref / 3600);
    e.m = to_bcd((t_ref / 60) % 60);
    e.s = to_bcd(t_ref % 60);
    e.p = pls_ref;
    e.e = err_ref;
    return e;
  endfunction

  task automatic model(input bit lv, input logic [7:0] lh, input logic [7:0] lm,
                       input logic [7:0] ls, input bit se, input logic [1:0] sel, input bit si);
    int h, m, s;
    bit ok_h, ok_m, ok_s;
    pls_ref = 0;
    err_ref = 0;
    if (lv) begin
      ok_h = dec(lh, 24, h);
      ok_m = dec(lm, 60, m);
      ok_s = dec(ls, 60, s);
      if (ok_h && ok_m && ok_s) begin
        t_ref   = h * 3600 + m * 60 + s;
        pre_ref = 0;
      end else begin
        err_ref = 1;
        if (se) pre_ref = 0;
        else pre_ref = (pre_ref == Div - 1) ? 0 : pre_ref + 1;
      end
    end else if (se) begin
      pre_ref = 0;
      if (si) begin
        h = t_ref / 3600;
        m = (t_ref / 60) % 60;
        s = t_ref % 60;
        case (sel)
          2'd0:    s = (s + 1) % 60;
          2'd1:    m = (m + 1) % 60;
          2'd2:    h = (h + 1) % 24;
          default: ;
        endcase
        t_ref = h * 3600 + m * 60 + s;
      end
    end else if (pre_ref == Div - 1) begin
      pre_ref = 0;
      t_ref   = (t_ref + 1) % Day;
      pls_ref = 1;
    end else begin
      pre_ref++;
    end
  endtask

  // Called just after a rising edge; drives, waits for the next edge, queues the expectation.
  task automatic step(input bit lv, input logic [7:0] lh, input logic [7:0] lm,
                      input logic [7:0] ls, input bit se, input logic [1:0] sel, input bit si);
    load_valid = lv;
    load_hour  = lh;
    load_min   = lm;
    load_sec   = ls;
    set_en     = se;
    set_sel    = sel;
    set_inc    = si;
    @(posedge clk);
    model(lv, lh, lm, ls, se, sel, si);
    exp_q.push_back(cur_exp());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00, 8'h00, 0, 2'd3, 0);
  endtask

  task automatic load(input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls,
                      input bit se);
    step(1, lh, lm, ls, se, 2'd3, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("curHour", 32'(curHour), 32'(e.h));
        check("curMin", 32'(curMin), 32'(e.m));
        check("curSec", 32'(curSec), 32'(e.s));
        check("sec_pulse", 32'(sec_pulse), 32'(e.p));
        check("load_err", 32'(load_err), 32'(e.e));
      end
    end
  end

  initial begin : stim
    int pulses;
    #3;
    check("reset_time", {8'h00, curHour, curMin, curSec}, 32'h0);
    check("reset_flags", {30'h0, sec_pulse, load_err}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Free run: one tick every Div cycles.
    pulses = 0;
    for (int i = 0; i < 4 * Div; i++) begin
      idle(1);
      pulses += int'(sec_pulse);
    end
    check("run_sec", 32'(curSec), 32'h04);
    check("run_pulses", 32'(pulses), 32'd4);

    // Midnight rollover.
    load(8'h23, 8'h59, 8'h58, 0);
    idle(2 * Div);
    check("midnight", {8'h00, curHour, curMin, curSec}, 32'h0);

    // Rejected loads.
    load(8'h24, 8'h10, 8'h10, 0);
    check("err_hour24", 32'(load_err), 32'd1);
    idle(1);
    check("err_clear", 32'(load_err), 32'd0);
    load(8'h10, 8'h5A, 8'h10, 0);
    check("err_min5a", 32'(load_err), 32'd1);

    // Set-mode minute stepping wraps without carrying.
    load(8'h07, 8'h58, 8'h10, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 8'h00, 8'h00, 1, 2'd1, 1);
    check("set_min", 32'(curMin), 32'h01);
    check("set_hour", 32'(curHour), 32'h07);
    idle(Div);
    check("leave_set_pulse", 32'(sec_pulse), 32'd1);

    // Load landing on the terminal count wins; the tick is dropped.
    while (pre_ref != Div - 1) idle(1);
    load(8'h11, 8'h22, 8'h33, 0);
    check("load_vs_tick", {8'h00, curHour, curMin, curSec}, 32'h00112233);
    check("load_vs_tick_p", 32'(sec_pulse), 32'd0);

    // Asynchronous reset mid-second.
    load(8'h12, 8'h34, 8'h56, 0);
    idle(2);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", {8'h00, curHour, curMin, curSec}, 32'h0);
    t_ref   = 0;
    pre_ref = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(Div);
    check("post_rst_tick", {23'h0, sec_pulse, curSec}, 32'h101);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit         lv, se, si;
      logic [7:0] lh, lm, ls;
      if ($urandom_range(31) == 0) se = ~set_en;
      else se = set_en;
      lv = ($urandom_range(15) == 0);
      si = ($urandom_range(3) == 0);
      if ($urandom_range(1) == 0) begin
        lh = to_bcd(int'($urandom_range(23)));
        lm = to_bcd(int'($urandom_range(59)));
        ls = to_bcd(int'($urandom_range(59)));
      end else begin
        lh = 8'($urandom);
        lm = 8'($urandom);
        ls = 8'($urandom);
      end
      step(lv, lh, lm, ls, se, 2'($urandom), si);
    end

    #10;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
